// File: rtl/lsu_arbiter.sv
// Load/store arbiter: latches one bundle of per-slot memory requests and
// serialises them onto a single memory port in slot order, stalling the core meanwhile.
module lsu_arbiter #(
    parameter int NUM_EU  = 3,
    parameter int TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  logic [NUM_EU-1:0]     is_load,
    input  logic [NUM_EU-1:0]     is_store,
    input  logic [NUM_EU*32-1:0]  ls_addr,
    input  logic [NUM_EU*32-1:0]  ls_wdata,
    input  logic [NUM_EU*2-1:0]   ls_size,
    input  logic [NUM_EU-1:0]     sign_extend,
    output logic                  busy,
    output logic [NUM_EU*32-1:0]  rdata,
    output logic [NUM_EU-1:0]     rdata_valid,
    output logic [NUM_EU-1:0]     fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [1:0]            mem_size,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam int SW = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SEL, ACC, DONE} state_t;

    state_t               state, state_nxt;
    logic [NUM_EU-1:0]    pend;
    logic [NUM_EU-1:0]    ld_q;
    logic [NUM_EU-1:0]    sext_q;
    logic [NUM_EU*32-1:0] addr_q;
    logic [NUM_EU*32-1:0] wdata_q;
    logic [NUM_EU*2-1:0]  size_q;
    logic [CW-1:0]        cnt;

    logic [NUM_EU-1:0]    req_vec;
    logic [SW-1:0]        sel;
    logic [31:0]          sel_addr;
    logic [1:0]           sel_size;
    logic                 bad;
    logic                 expire;
    logic                 accept;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic sx);
        case (sz)
            2'd0:    extend = sx ? {{24{d[7]}}, d[7:0]} : {24'b0, d[7:0]};
            2'd1:    extend = sx ? {{16{d[15]}}, d[15:0]} : {16'b0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // Slot currently being serviced: lowest pending bit. It stays pending through ACC.
    always_comb begin
        sel = '0;
        for (int i = NUM_EU - 1; i >= 0; i--) begin
            if (pend[i]) sel = SW'(i);
        end
    end

    always_comb begin
        req_vec  = is_load | is_store;
        accept   = issue && (req_vec != '0);
        sel_addr = addr_q[sel*32 +: 32];
        sel_size = size_q[sel*2 +: 2];
        bad      = (sel_size == 2'd3) ||
                   (sel_size == 2'd1 && sel_addr[0]) ||
                   (sel_size == 2'd2 && sel_addr[1:0] != 2'b00);
        // An ack in the expiry cycle takes priority over the timeout.
        expire   = (TIMEOUT != 0) && !mem_ack && (cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEL;
            SEL: begin
                if (pend == '0)  state_nxt = DONE;
                else if (!bad)   state_nxt = ACC;
            end
            ACC:  if (mem_ack || expire) state_nxt = SEL;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            rdata       <= '0;
            rdata_valid <= '0;
            fault       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_size    <= '0;
            pend        <= '0;
            ld_q        <= '0;
            sext_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            cnt         <= '0;
        end else begin
            rdata_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pend    <= req_vec;
                        ld_q    <= is_load;
                        sext_q  <= sign_extend;
                        addr_q  <= ls_addr;
                        wdata_q <= ls_wdata;
                        size_q  <= ls_size;
                        fault   <= '0;
                        busy    <= 1'b1;
                    end
                end
                SEL: begin
                    if (pend != '0) begin
                        if (bad) begin
                            fault[sel] <= 1'b1;
                            pend[sel]  <= 1'b0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= !ld_q[sel];
                            mem_addr  <= sel_addr;
                            mem_wdata <= wdata_q[sel*32 +: 32];
                            mem_size  <= sel_size;
                            cnt       <= '0;
                        end
                    end
                end
                ACC: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        pend[sel] <= 1'b0;
                        if (!mem_we) begin
                            rdata[sel*32 +: 32] <= extend(mem_rdata, mem_size, sext_q[sel]);
                            rdata_valid[sel]    <= 1'b1;
                        end
                    end else if (expire) begin
                        mem_req    <= 1'b0;
                        fault[sel] <= 1'b1;
                        pend[sel]  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter: expected memory accesses and load returns are
// queued when a bundle is issued and matched against what the arbiter produces.
module tb_lsu_arbiter;

    localparam int NUM_EU = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } acc_t;

    typedef struct packed {
        logic [1:0]  slot;
        logic [31:0] data;
    } rd_t;

    logic                 clk, rst, issue;
    logic [NUM_EU-1:0]    is_load, is_store, sign_extend;
    logic [NUM_EU*32-1:0] ls_addr, ls_wdata;
    logic [NUM_EU*2-1:0]  ls_size;
    logic                 busy;
    logic [NUM_EU*32-1:0] rdata;
    logic [NUM_EU-1:0]    rdata_valid, fault;
    logic                 mem_req, mem_we, mem_ack;
    logic [31:0]          mem_addr, mem_wdata, mem_rdata;
    logic [1:0]           mem_size;

    lsu_arbiter #(.NUM_EU(NUM_EU), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .issue(issue),
        .is_load(is_load), .is_store(is_store),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_size(ls_size),
        .sign_extend(sign_extend),
        .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   fails  = 0;

    acc_t exp_acc[$], obs_acc[$];
    rd_t  exp_rd[$],  obs_rd[$];
    int   ack_delay;
    logic [31:0] rsp_data;
    int   wait_cnt;
    bit   req_active;
    acc_t cur_acc;
    int   req_cycles;
    int   hold_viol;
    int   rv_cnt[NUM_EU];

    // One clock: sample at the falling edge, record what the arbiter did, answer memory.
    task automatic step();
        acc_t now;
        @(negedge clk);
        for (int i = 0; i < NUM_EU; i++) begin
            if (rdata_valid[i]) begin
                obs_rd.push_back('{slot: 2'(i), data: rdata[i*32 +: 32]});
                rv_cnt[i]++;
            end
        end
        now = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, size: mem_size};
        if (mem_req) begin
            req_cycles++;
            if (!req_active) begin
                obs_acc.push_back(now);
                cur_acc    = now;
                req_active = 1'b1;
                wait_cnt   = 0;
            end else begin
                if (now != cur_acc) hold_viol++;
                wait_cnt++;
            end
        end else begin
            req_active = 1'b0;
        end
        mem_ack   = mem_req && (ack_delay >= 0) && (wait_cnt == ack_delay);
        mem_rdata = rsp_data;
        if (mem_ack) req_active = 1'b0;
    endtask

    task automatic new_case();
        is_load = '0; is_store = '0; sign_extend = '0;
        ls_addr = '0; ls_wdata = '0; ls_size = '0;
        exp_acc.delete(); obs_acc.delete(); exp_rd.delete(); obs_rd.delete();
        req_cycles = 0; hold_viol = 0;
        for (int i = 0; i < NUM_EU; i++) rv_cnt[i] = 0;
    endtask

    task automatic set_slot(input int i, input logic ld, input logic st, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] sz, input logic sx);
        is_load[i]            = ld;
        is_store[i]           = st;
        ls_addr[i*32 +: 32]   = a;
        ls_wdata[i*32 +: 32]  = wd;
        ls_size[i*2 +: 2]     = sz;
        sign_extend[i]        = sx;
    endtask

    task automatic do_issue();
        issue = 1'b1;
        step();
        issue = 1'b0;
    endtask

    task automatic run_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        if (busy !== 1'b0) cyc = -1;
    endtask

    task automatic test_reset();
        new_case();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({busy, mem_req, mem_we, rdata_valid, fault} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%b req=%b we=%b rv=%b fault=%b, required all 0",
                     busy, mem_req, mem_we, rdata_valid, fault);
        end
        checks++;
        if (rdata !== '0) begin
            fails++;
            $display("FAIL reset_rdata: got %h, required 0", rdata);
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_size} !== '0) begin
            fails++;
            $display("FAIL reset_mem: addr=%h wdata=%h size=%0d, required 0",
                     mem_addr, mem_wdata, mem_size);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_byte_load();
        int cyc;
        new_case();
        set_slot(0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd0, 1'b1);
        ack_delay = 2; rsp_data = 32'h0000_0080;
        exp_acc.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, size: 2'd0});
        exp_rd.push_back('{slot: 2'd0, data: 32'hFFFF_FF80});
        do_issue();
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL byte_busy_rise: busy=%b, required 1", busy);
        end
        run_idle(cyc);
        checks++;
        if (cyc != 6) begin
            fails++;
            $display("FAIL byte_latency: busy fell after %0d cycles, required 6", cyc);
        end
        checks++;
        if (rv_cnt[0] != 1 || rv_cnt[1] != 0 || rv_cnt[2] != 0) begin
            fails++;
            $display("FAIL byte_rv_pulses: %0d/%0d/%0d, required 1/0/0",
                     rv_cnt[0], rv_cnt[1], rv_cnt[2]);
        end
        checks++;
        if (rdata[31:0] !== 32'hFFFF_FF80) begin
            fails++;
            $display("FAIL byte_rdata_hold: rdata0=%h, required ffffff80", rdata[31:0]);
        end
        checks++;
        if (obs_acc.size() != exp_acc.size() || obs_rd.size() != exp_rd.size()) begin
            fails++;
            $display("FAIL byte_counts: acc=%0d rd=%0d, required %0d/%0d",
                     obs_acc.size(), obs_rd.size(), exp_acc.size(), exp_rd.size());
        end
        while (exp_acc.size() != 0 && obs_acc.size() != 0) begin
            acc_t e = exp_acc.pop_front();
            acc_t o = obs_acc.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL byte_access: got %h, required %h", o, e);
            end
        end
        while (exp_rd.size() != 0 && obs_rd.size() != 0) begin
            rd_t e = exp_rd.pop_front();
            rd_t o = obs_rd.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL byte_rd: got %h, required %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        new_case();
        for (int i = 0; i < NUM_EU; i++) begin
            set_slot(i, 1'b0, 1'b1, 32'(i * 4), 32'hA5A5_0000 + 32'(i), 2'd2, 1'b0);
            exp_acc.push_back('{we: 1'b1, addr: 32'(i * 4), wdata: 32'hA5A5_0000 + 32'(i),
                                size: 2'd2});
        end
        ack_delay = 0; rsp_data = 32'hDEAD_BEEF;
        do_issue();
        run_idle(cyc);
        checks++;
        if (cyc != 8) begin
            fails++;
            $display("FAIL b2b_latency: busy fell after %0d cycles, required 8", cyc);
        end
        checks++;
        if (obs_acc.size() != 3 || obs_rd.size() != 0 || hold_viol != 0) begin
            fails++;
            $display("FAIL b2b_counts: acc=%0d rd=%0d holdviol=%0d, required 3/0/0",
                     obs_acc.size(), obs_rd.size(), hold_viol);
        end
        while (exp_acc.size() != 0 && obs_acc.size() != 0) begin
            acc_t e = exp_acc.pop_front();
            acc_t o = obs_acc.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL b2b_access: got %h, required %h", o, e);
            end
        end
        checks++;
        if (rdata[31:0] !== 32'hFFFF_FF80 || fault !== 3'b000) begin
            fails++;
            $display("FAIL b2b_side: rdata0=%h fault=%b, required ffffff80/000",
                     rdata[31:0], fault);
        end
    endtask

    task automatic test_misaligned();
        int cyc;
        new_case();
        set_slot(1, 1'b1, 1'b0, 32'h201, 32'h0, 2'd1, 1'b0);
        set_slot(2, 1'b1, 1'b0, 32'h204, 32'h0, 2'd2, 1'b0);
        ack_delay = 0; rsp_data = 32'h1234_5678;
        exp_acc.push_back('{we: 1'b0, addr: 32'h204, wdata: 32'h0, size: 2'd2});
        exp_rd.push_back('{slot: 2'd2, data: 32'h1234_5678});
        do_issue();
        run_idle(cyc);
        checks++;
        if (cyc != 5) begin
            fails++;
            $display("FAIL misalign_latency: busy fell after %0d cycles, required 5", cyc);
        end
        checks++;
        if (fault !== 3'b010) begin
            fails++;
            $display("FAIL misalign_fault: got %b, required 010", fault);
        end
        checks++;
        if (obs_acc.size() != 1 || obs_rd.size() != 1 || rv_cnt[1] != 0) begin
            fails++;
            $display("FAIL misalign_counts: acc=%0d rd=%0d rv1=%0d, required 1/1/0",
                     obs_acc.size(), obs_rd.size(), rv_cnt[1]);
        end
        while (exp_acc.size() != 0 && obs_acc.size() != 0) begin
            acc_t e = exp_acc.pop_front();
            acc_t o = obs_acc.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL misalign_access: got %h, required %h", o, e);
            end
        end
        while (exp_rd.size() != 0 && obs_rd.size() != 0) begin
            rd_t e = exp_rd.pop_front();
            rd_t o = obs_rd.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL misalign_rd: got %h, required %h", o, e);
            end
        end
        checks++;
        if (rdata[95:64] !== 32'h1234_5678 || rdata[31:0] !== 32'hFFFF_FF80) begin
            fails++;
            $display("FAIL misalign_rdata: r2=%h r0=%h, required 12345678/ffffff80",
                     rdata[95:64], rdata[31:0]);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        new_case();
        set_slot(0, 1'b1, 1'b0, 32'h40, 32'h0, 2'd0, 1'b0);
        ack_delay = -1; rsp_data = 32'h0000_0011;
        exp_acc.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, size: 2'd0});
        do_issue();
        run_idle(cyc);
        checks++;
        if (cyc != 7) begin
            fails++;
            $display("FAIL timeout_latency: busy fell after %0d cycles, required 7", cyc);
        end
        checks++;
        if (req_cycles != 4 || hold_viol != 0) begin
            fails++;
            $display("FAIL timeout_req_len: mem_req high %0d cycles (holdviol=%0d), required 4",
                     req_cycles, hold_viol);
        end
        checks++;
        if (fault !== 3'b001) begin
            fails++;
            $display("FAIL timeout_fault: got %b, required 001", fault);
        end
        checks++;
        if (rdata[31:0] !== 32'hFFFF_FF80 || obs_rd.size() != 0) begin
            fails++;
            $display("FAIL timeout_rdata: rdata0=%h returns=%0d, required ffffff80/0",
                     rdata[31:0], obs_rd.size());
        end
        while (exp_acc.size() != 0 && obs_acc.size() != 0) begin
            acc_t e = exp_acc.pop_front();
            acc_t o = obs_acc.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL timeout_access: got %h, required %h", o, e);
            end
        end
    endtask

    task automatic test_extend();
        int cyc;
        new_case();
        // Slot 0 also requests a store: the load must win.
        set_slot(0, 1'b1, 1'b1, 32'h10, 32'h0, 2'd1, 1'b0);
        set_slot(1, 1'b1, 1'b0, 32'h12, 32'h0, 2'd1, 1'b1);
        set_slot(2, 1'b1, 1'b0, 32'h03, 32'h0, 2'd0, 1'b0);
        ack_delay = 1; rsp_data = 32'h5A5A_8F81;
        exp_acc.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, size: 2'd1});
        exp_acc.push_back('{we: 1'b0, addr: 32'h12, wdata: 32'h0, size: 2'd1});
        exp_acc.push_back('{we: 1'b0, addr: 32'h03, wdata: 32'h0, size: 2'd0});
        exp_rd.push_back('{slot: 2'd0, data: 32'h0000_8F81});
        exp_rd.push_back('{slot: 2'd1, data: 32'hFFFF_8F81});
        exp_rd.push_back('{slot: 2'd2, data: 32'h0000_0081});
        do_issue();
        checks++;
        if (fault !== 3'b000) begin
            fails++;
            $display("FAIL extend_fault_clear: got %b, required 000", fault);
        end
        run_idle(cyc);
        checks++;
        if (cyc < 0 || obs_acc.size() != 3 || obs_rd.size() != 3) begin
            fails++;
            $display("FAIL extend_counts: cyc=%0d acc=%0d rd=%0d, required done/3/3",
                     cyc, obs_acc.size(), obs_rd.size());
        end
        while (exp_acc.size() != 0 && obs_acc.size() != 0) begin
            acc_t e = exp_acc.pop_front();
            acc_t o = obs_acc.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL extend_access: got %h, required %h", o, e);
            end
        end
        while (exp_rd.size() != 0 && obs_rd.size() != 0) begin
            rd_t e = exp_rd.pop_front();
            rd_t o = obs_rd.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL extend_rd: got %h, required %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int cyc;
        int n;
        new_case();
        set_slot(0, 1'b1, 1'b0, 32'h80, 32'h0, 2'd2, 1'b0);
        ack_delay = -1; rsp_data = 32'h0;
        do_issue();
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_req_rise: mem_req=%b after %0d cycles, required 1", mem_req, n);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || rdata !== '0 || fault !== '0) begin
            fails++;
            $display("FAIL rstmid_clear: req=%b busy=%b rdata=%h fault=%b, required all 0",
                     mem_req, busy, rdata, fault);
        end
        step();
        new_case();
        set_slot(0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        ack_delay = 1; rsp_data = 32'hCAFE_F00D;
        exp_rd.push_back('{slot: 2'd0, data: 32'hCAFE_F00D});
        do_issue();
        run_idle(cyc);
        checks++;
        if (cyc != 5 || obs_rd.size() != 1) begin
            fails++;
            $display("FAIL rstmid_fresh: cyc=%0d returns=%0d, required 5/1", cyc, obs_rd.size());
        end
        while (exp_rd.size() != 0 && obs_rd.size() != 0) begin
            rd_t e = exp_rd.pop_front();
            rd_t o = obs_rd.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL rstmid_rd: got %h, required %h", o, e);
            end
        end
    endtask

    task automatic test_empty_and_ignored();
        int cyc;
        new_case();
        ack_delay = 0; rsp_data = 32'h0;
        do_issue();
        step(); step(); step();
        checks++;
        if (busy !== 1'b0 || req_cycles != 0) begin
            fails++;
            $display("FAIL empty_issue: busy=%b req_cycles=%0d, required 0/0", busy, req_cycles);
        end
        new_case();
        set_slot(0, 1'b0, 1'b1, 32'h30, 32'h0BAD_CAFE, 2'd2, 1'b0);
        ack_delay = 3; rsp_data = 32'h7777_7777;
        exp_acc.push_back('{we: 1'b1, addr: 32'h30, wdata: 32'h0BAD_CAFE, size: 2'd2});
        do_issue();
        new_case();
        exp_acc.push_back('{we: 1'b1, addr: 32'h30, wdata: 32'h0BAD_CAFE, size: 2'd2});
        set_slot(1, 1'b1, 1'b0, 32'h44, 32'h0, 2'd2, 1'b0);
        do_issue();
        run_idle(cyc);
        checks++;
        if (cyc < 0 || obs_acc.size() != 1 || obs_rd.size() != 0) begin
            fails++;
            $display("FAIL ignored_issue: cyc=%0d acc=%0d rd=%0d, required done/1/0",
                     cyc, obs_acc.size(), obs_rd.size());
        end
        while (exp_acc.size() != 0 && obs_acc.size() != 0) begin
            acc_t e = exp_acc.pop_front();
            acc_t o = obs_acc.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL ignored_access: got %h, required %h", o, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; issue = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        ack_delay = 0; rsp_data = '0; wait_cnt = 0; req_active = 1'b0; cur_acc = '0;
        new_case();
        test_reset();
        test_byte_load();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_extend();
        test_reset_mid_access();
        test_empty_and_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
